// File: rtl/pcm_gain_ramp.sv
// Gain stage for 16-bit PCM around an external signed 16x16 multiplier.
// Ramps the gain toward a target, then rounds and saturates the product back to 16 bits.
module pcm_gain_ramp #(
  parameter int                 MUL_LAT    = 3,
  parameter logic signed [15:0] GAIN_RESET = 16'sd16384,
  parameter int                 RAMP_STEP  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic signed [15:0] in_data,
  input  logic signed [15:0] gain_target,
  input  logic               gain_load,
  input  logic               sat_clr,
  output logic signed [15:0] mul_a,
  output logic signed [15:0] mul_b,
  input  logic signed [31:0] mul_p,
  output logic               out_valid,
  output logic signed [15:0] out_data,
  output logic               ramp_busy,
  output logic               sat_flag
);

  localparam logic signed [16:0] STEP17 = 17'(RAMP_STEP);
  localparam logic signed [15:0] STEP16 = 16'(RAMP_STEP);

  logic signed [15:0]  cur_gain_r;
  logic signed [15:0]  tgt_gain_r;
  logic signed [15:0]  mul_a_r;
  logic signed [15:0]  mul_b_r;
  logic [MUL_LAT:0]    vld_pipe_r;
  logic signed [15:0]  out_data_r;
  logic                out_valid_r;
  logic                sat_flag_r;

  logic signed [16:0]  diff_s;
  logic signed [15:0]  next_gain_s;
  logic signed [31:0]  rnd_s;
  logic signed [31:0]  r_s;
  logic                sat_hi_s;
  logic                sat_lo_s;
  logic signed [15:0]  sat_data_s;

  // Next ramp position: one bounded step toward the target, landing exactly on it.
  always_comb begin
    diff_s      = {tgt_gain_r[15], tgt_gain_r} - {cur_gain_r[15], cur_gain_r};
    next_gain_s = cur_gain_r;
    if (diff_s > STEP17) begin
      next_gain_s = cur_gain_r + STEP16;
    end else if (diff_s < -STEP17) begin
      next_gain_s = cur_gain_r - STEP16;
    end else begin
      next_gain_s = tgt_gain_r;
    end
  end

  // Round-half-up of the Q2.14 product, then clamp to the 16-bit range.
  always_comb begin
    rnd_s      = mul_p + 32'sd8192;
    r_s        = rnd_s >>> 14;
    sat_hi_s   = (r_s > 32'sd32767);
    sat_lo_s   = (r_s < -32'sd32768);
    sat_data_s = r_s[15:0];
    if (sat_hi_s) begin
      sat_data_s = 16'sh7fff;
    end else if (sat_lo_s) begin
      sat_data_s = 16'sh8000;
    end else begin
      sat_data_s = r_s[15:0];
    end
  end

  // Gain state: the sample in this cycle already captured the old cur_gain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_gain_r <= GAIN_RESET;
      tgt_gain_r <= GAIN_RESET;
    end else begin
      if (in_valid) begin
        cur_gain_r <= next_gain_s;
      end
      if (gain_load) begin
        tgt_gain_r <= gain_target;
      end
    end
  end

  // Multiplier operand registers and the valid shadow of the multiplier pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_r    <= 16'sd0;
      mul_b_r    <= 16'sd0;
      vld_pipe_r <= '0;
    end else begin
      if (in_valid) begin
        mul_a_r <= in_data;
        mul_b_r <= cur_gain_r;
      end
      vld_pipe_r <= {vld_pipe_r[MUL_LAT-1:0], in_valid};
    end
  end

  // Output sample register; holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= 16'sd0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= vld_pipe_r[MUL_LAT];
      if (vld_pipe_r[MUL_LAT]) begin
        out_data_r <= sat_data_s;
      end
    end
  end

  // Sticky saturation flag; a clear wins over a coincident set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag_r <= 1'b0;
    end else if (sat_clr) begin
      sat_flag_r <= 1'b0;
    end else if (vld_pipe_r[MUL_LAT] && (sat_hi_s || sat_lo_s)) begin
      sat_flag_r <= 1'b1;
    end
  end

  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign sat_flag  = sat_flag_r;
  assign ramp_busy = (cur_gain_r != tgt_gain_r);

endmodule

// File: tb/tb_pcm_gain_ramp.sv
// Scoreboard bench for pcm_gain_ramp with a behavioural 3-stage multiplier.
// Expected outputs come from a reference gain model and are matched on each out_valid.
module tb_pcm_gain_ramp;

  localparam int STEP = 4096;
  localparam int LAT  = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_data = 16'sd0;
  logic signed [15:0] gain_target = 16'sd0;
  logic               gain_load = 1'b0;
  logic               sat_clr = 1'b0;
  logic signed [15:0] mul_a;
  logic signed [15:0] mul_b;
  logic signed [31:0] mul_p;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               ramp_busy;
  logic               sat_flag;

  pcm_gain_ramp #(.MUL_LAT(3), .GAIN_RESET(16'sd16384), .RAMP_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .gain_target(gain_target), .gain_load(gain_load), .sat_clr(sat_clr),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .out_valid(out_valid),
    .out_data(out_data), .ramp_busy(ramp_busy), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: three pipe registers, reset by the inverted rst_n.
  logic signed [31:0] p1, p2, p3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= 32'sd0; p2 <= 32'sd0; p3 <= 32'sd0;
    end else begin
      p1 <= mul_a * mul_b;
      p2 <= p1;
      p3 <= p2;
    end
  end
  assign mul_p = p3;

  typedef struct { int data; int cyc; } exp_t;
  exp_t sb_q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int n_out = 0;
  int model_cur = 16384;
  int model_tgt = 16384;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int scale(input int d, input int g);
    int r;
    r = (d * g + 8192) >>> 14;
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return r;
  endfunction

  // Output monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      n_out++;
      if (sb_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("out_data", int'(out_data), e.data);
        chk("latency", cyc - e.cyc, LAT);
      end
    end
  end

  task automatic send(input int d, input logic ld, input int tg);
    sb_q.push_back('{data: scale(d, model_cur), cyc: cyc});
    in_valid = 1'b1; in_data = 16'(d); gain_load = ld; gain_target = 16'(tg);
    if (model_tgt - model_cur > STEP) model_cur += STEP;
    else if (model_tgt - model_cur < -STEP) model_cur -= STEP;
    else model_cur = model_tgt;
    if (ld) model_tgt = tg;
    @(posedge clk); #1;
    in_valid = 1'b0; gain_load = 1'b0;
  endtask

  task automatic load_only(input int tg);
    gain_load = 1'b1; gain_target = 16'(tg);
    model_tgt = tg;
    @(posedge clk); #1;
    gain_load = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 20 && model_cur != model_tgt; i++) send(0, 1'b0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int start_out;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_ramp_busy", ramp_busy, 0);
    chk("rst_mul_b", int'(mul_b), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // unity gain
    send(1000, 1'b0, 0);
    chk("unity_mul_a", int'(mul_a), 1000);
    chk("unity_mul_b", int'(mul_b), 16384);
    drain();
    chk("unity_sat", sat_flag, 0);
    chk("unity_busy", ramp_busy, 0);

    // rounding at gain 0.5
    load_only(8192);
    chk("round_busy", ramp_busy, 1);
    settle();
    chk("round_settled", ramp_busy, 0);
    send(-3, 1'b0, 0);
    send(3, 1'b0, 0);
    drain();

    // saturation both ways, sticky flag, clear
    load_only(32767);
    settle();
    send(30000, 1'b0, 0);
    send(-30000, 1'b0, 0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("sat_sticky", sat_flag, 1);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("sat_cleared", sat_flag, 0);

    // ramp 1.0 -> 0 in four steps
    load_only(16384);
    settle();
    load_only(0);
    for (int i = 0; i < 5; i++) begin
      chk("ramp_busy_pre", ramp_busy, (model_cur != model_tgt) ? 1 : 0);
      send(10000, 1'b0, 0);
    end
    chk("ramp_busy_done", ramp_busy, 0);
    drain();

    // gain_load coinciding with a sample
    send(1000, 1'b1, 16384);
    send(1000, 1'b0, 0);
    send(1000, 1'b0, 0);
    drain();

    // back-to-back burst
    start_out = n_out;
    for (int i = 0; i < 20; i++) send($signed(16'($urandom_range(0, 65535))), 1'b0, 0);
    drain();
    chk("burst_count", n_out - start_out, 20);

    // reset with samples in flight
    load_only(32767);
    settle();
    send(30000, 1'b0, 0);
    drain();
    chk("pre_reset_sat", sat_flag, 1);
    load_only(0);
    send(1000, 1'b0, 0);
    send(2000, 1'b0, 0);
    send(3000, 1'b0, 0);
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    sb_q.delete();
    model_cur = 16384;
    model_tgt = 16384;
    chk("post_reset_sat", sat_flag, 0);
    chk("post_reset_busy", ramp_busy, 0);
    chk("post_reset_valid", out_valid, 0);
    start_out = n_out;
    @(posedge clk); #1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_reset_no_out", n_out - start_out, 0);
    send(1000, 1'b0, 0);
    chk("post_reset_mul_b", int'(mul_b), 16384);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
